// File: rtl/int_arbiter_if.sv
// int_arbiter_if: arbiter bus; slave=arbiter (done/mask/int_ack/eret in; int_req/int_addr/active_id/busy/pending/overrun out), master=opposite side
interface int_arbiter_if;
  logic [3:0] done;
  logic [3:0] mask;
  logic int_ack;
  logic eret;
  logic int_req;
  logic [31:0] int_addr;
  logic [1:0] active_id;
  logic busy;
  logic [3:0] pending;
  logic [3:0] overrun;
  modport slave (
    input done, mask, int_ack, eret,
    output int_req, int_addr, active_id, busy, pending, overrun
  );
  modport master (
    output done, mask, int_ack, eret,
    input int_req, int_addr, active_id, busy, pending, overrun
  );
endinterface

// File: rtl/int_arbiter.sv
// int_arbiter: 4-source vectored interrupt controller; ports clk, reset, bus (int_arbiter_if.slave), all outputs registered
module int_arbiter #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input logic clk,
  input logic reset,
  int_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;
  logic [3:0] done_q;
  logic [3:0] ev;
  logic [3:0] elig;
  logic [3:0] clr;
  logic [1:0] win;
  assign ev = bus.done & ~done_q;
  assign elig = bus.pending & bus.mask;
  assign clr = (state == REQ && bus.int_ack) ? 4'b0001 << bus.active_id : 4'b0000;
  always_comb win = elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done_q <= 4'b0;
      bus.pending <= 4'b0;
      bus.overrun <= 4'b0;
      bus.int_req <= 1'b0;
      bus.busy <= 1'b0;
      bus.active_id <= 2'd0;
      bus.int_addr <= VEC_BASE;
    end else begin
      done_q <= bus.done;
      bus.pending <= (bus.pending & ~clr) | ev;
      bus.overrun <= (bus.overrun & ~clr) | (ev & bus.pending);
      case (state)
        IDLE: if (|elig) begin
          state <= REQ;
          bus.int_req <= 1'b1;
          bus.active_id <= win;
          bus.int_addr <= VEC_BASE + {30'b0, win} * VEC_STRIDE;
        end
        REQ: if (bus.int_ack) begin
          state <= SERVICE;
          bus.int_req <= 1'b0;
          bus.busy <= 1'b1;
        end
        SERVICE: if (bus.eret) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed plus randomized checks of int_arbiter against a behavioural model
module tb_int_arbiter;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0010;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int_arbiter_if bus();
  int_arbiter #(.VEC_BASE(VB), .VEC_STRIDE(VS)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [3:0] m_pend, m_ovr, m_dq;
  logic m_req, m_busy;
  logic [1:0] m_id;
  logic [31:0] m_addr;
  task automatic model_edge();
    logic [3:0] np, no;
    int w;
    if (reset) begin
      m_pend = 0; m_ovr = 0; m_dq = 0; m_req = 0; m_busy = 0; m_id = 0; m_addr = VB;
    end else begin
      np = m_pend;
      no = m_ovr;
      if (m_req && bus.int_ack) begin
        np[m_id] = 1'b0;
        no[m_id] = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if (bus.done[i] && !m_dq[i]) begin
          if (m_pend[i]) no[i] = 1'b1;
          np[i] = 1'b1;
        end
      if (!m_req && !m_busy) begin
        w = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i] && bus.mask[i]) w = i;
        if (w >= 0) begin
          m_req = 1; m_id = 2'(w); m_addr = VB + 32'(w) * VS;
        end
      end else if (m_req) begin
        if (bus.int_ack) begin m_req = 0; m_busy = 1; end
      end else if (bus.eret) m_busy = 0;
      m_pend = np;
      m_ovr = no;
      m_dq = bus.done;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("int_req", 32'(bus.int_req), 32'(m_req));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("active_id", 32'(bus.active_id), 32'(m_id));
    chk("int_addr", bus.int_addr, m_addr);
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask
  task automatic step(input logic [3:0] d, input logic [3:0] m, input logic a, input logic e, input logic r);
    bus.done = d; bus.mask = m; bus.int_ack = a; bus.eret = e; reset = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  initial begin
    step(4'h0, 4'hF, 0, 0, 1);
    step(4'h0, 4'hF, 0, 0, 1);
    chk("rst_addr", bus.int_addr, 32'h100);
    chk("rst_req", 32'(bus.int_req), 32'd0);
    step(4'h4, 4'hF, 0, 0, 0);
    chk("t1_pending", 32'(bus.pending), 32'h4);
    chk("t1_req_early", 32'(bus.int_req), 32'd0);
    step(4'h0, 4'hF, 0, 0, 0);
    chk("t1_req", 32'(bus.int_req), 32'd1);
    chk("t1_id", 32'(bus.active_id), 32'd2);
    chk("t1_addr", bus.int_addr, 32'h120);
    step(4'h0, 4'hF, 1, 0, 0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    step(4'h0, 4'hF, 0, 1, 0);
    step(4'hA, 4'hF, 0, 0, 0);
    step(4'h0, 4'hF, 0, 0, 0);
    chk("t2_addr1", bus.int_addr, 32'h110);
    step(4'h0, 4'hF, 1, 1, 0);
    step(4'h0, 4'hF, 0, 1, 0);
    chk("t2_idle_gap", 32'(bus.int_req), 32'd0);
    step(4'h0, 4'hF, 0, 0, 0);
    chk("t2_req3", 32'(bus.int_req), 32'd1);
    chk("t2_id3", 32'(bus.active_id), 32'd3);
    chk("t2_addr3", bus.int_addr, 32'h130);
    step(4'h0, 4'hF, 1, 0, 0);
    step(4'h0, 4'hF, 0, 1, 0);
    step(4'h1, 4'hE, 0, 0, 0);
    chk("t3_pend0", 32'(bus.pending), 32'h1);
    step(4'h0, 4'hE, 0, 0, 0);
    chk("t3_masked", 32'(bus.int_req), 32'd0);
    step(4'h0, 4'hF, 0, 0, 0);
    chk("t3_req", 32'(bus.int_req), 32'd1);
    chk("t3_addr", bus.int_addr, 32'h100);
    step(4'h0, 4'hF, 1, 0, 0);
    step(4'h0, 4'hF, 0, 1, 0);
    step(4'h2, 4'hF, 0, 0, 0);
    step(4'h0, 4'hF, 0, 0, 0);
    step(4'h2, 4'hF, 0, 0, 0);
    chk("t4_ovr", 32'(bus.overrun), 32'h2);
    step(4'h0, 4'hF, 1, 0, 0);
    chk("t4_ack_pend", 32'(bus.pending), 32'h0);
    chk("t4_ack_ovr", 32'(bus.overrun), 32'h0);
    step(4'h0, 4'hF, 0, 1, 0);
    step(4'h2, 4'hF, 0, 0, 0);
    step(4'h0, 4'hF, 0, 0, 0);
    step(4'h2, 4'hF, 1, 0, 0);
    chk("t4_setwin_pend", 32'(bus.pending), 32'h2);
    chk("t4_setwin_ovr", 32'(bus.overrun), 32'h2);
    step(4'h0, 4'hF, 0, 1, 0);
    step(4'h0, 4'hF, 0, 0, 0);
    step(4'h0, 4'hF, 1, 0, 0);
    step(4'h8, 4'hF, 0, 0, 0);
    chk("t5_svc_pend", 32'(bus.pending), 32'h8);
    step(4'h0, 4'hF, 0, 0, 1);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_pend", 32'(bus.pending), 32'h0);
    step(4'h0, 4'hF, 1, 0, 0);
    step(4'h0, 4'hF, 0, 1, 0);
    chk("t5_stray", 32'(bus.int_req), 32'd0);
    for (int n = 0; n < 3000; n++)
      step(4'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF,
           1'($urandom_range(2) == 0), 1'($urandom_range(3) == 0), 1'($urandom_range(99) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_arbiter.md
# int_arbiter

Four-source vectored interrupt controller placed between the accelerator `done` flags and the single-cycle MIPS core. It detects completion events, latches them as pending, and picks the highest-priority enabled source. It presents that source's handler vector to the core and holds the request until the core acknowledges the redirect, then blocks further requests until the handler signals return. One interrupt is in service at a time; there is no nesting.

## Interface
Parameters:
- VEC_BASE, 32'h0000_0100, byte address of the handler for source 0
- VEC_STRIDE, 32'h0000_0010, byte spacing between consecutive handler vectors

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- done  in  4  completion levels from accelerators; done[i] is source i
- mask  in  4  per-source enable; 1 = may raise a request
- int_ack  in  1  core has redirected PC to int_addr; single-cycle pulse
- eret  in  1  core is returning from the handler; single-cycle pulse
- int_req  out  1  interrupt request to the core
- int_addr  out  32  handler vector for active_id; registered
- active_id  out  2  source currently requested or in service
- busy  out  1  handler in service (state SERVICE)
- pending  out  4  latched, un-acknowledged events (masked ones included)
- overrun  out  4  sticky; an event arrived on source i while pending[i] was already 1

## Operation
- Edge detect: a done_q register samples done. An event on source i is done[i]=1 && done_q[i]=0 at a clock edge.
- Event handling: an event sets pending[i]. If pending[i] is already 1, the event also sets overrun[i].
- Masking: mask does not affect pending or overrun. A masked pending bit is retained and becomes eligible when unmasked.
- Priority: fixed, lowest index wins among (pending & mask).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if (pending & mask) != 0, latch the winner into active_id, load int_addr = VEC_BASE + active_id*VEC_STRIDE (mod 2^32), and go to REQ.
  - REQ: int_req=1. On int_ack, clear pending[active_id] and overrun[active_id], then go to SERVICE. mask or pending changes in REQ never change active_id or withdraw the request.
  - SERVICE: busy=1, int_req=0. On eret, go to IDLE.
- Ignored inputs: int_ack outside REQ and eret outside SERVICE have no effect.
- Simultaneous set and clear on the same source (event on active_id in the ack cycle): the set wins. pending stays 1; overrun is cleared, then set only if the pending bit was already 1 before the ack (it was, so overrun=1).
- Simultaneous events on several sources: all pending bits set in the same edge.
- int_ack and eret asserted together: only the one matching the current state acts.

## Timing
- Reset values: state IDLE, int_req=0, busy=0, active_id=0, int_addr=VEC_BASE, pending=0, overrun=0, done_q=0.
- A done line already high on the first edge after reset counts as an event.
- Reset mid-operation (any state) abandons the request or service immediately, with no ack needed.
- Event to pending: pending[i]=1 after edge k, where edge k is the edge at which the event is sampled.
- Pending to request: int_req=1 after edge k+1. Event-to-int_req latency is 2 cycles.
- int_addr and active_id are valid in the same cycle int_req rises and stay stable until the next IDLE to REQ transition.
- int_ack sampled at edge m: after edge m, int_req=0, busy=1, pending bit cleared.
- eret sampled at edge n: busy=0 after edge n. The earliest next int_req is after edge n+1, so there is at least one IDLE cycle.
- No combinational path from any input to any output.

## Test plan
- Reset, then pulse done[2] high for 1 cycle with mask=4'hF -> pending=4'b0100 after 1 edge, int_req=1 after 2 edges, active_id=2, int_addr=32'h0000_0120.
- Raise done[3] and done[1] on the same edge, mask=4'hF, ack then eret -> source 1 serviced first (int_addr=32'h110). After eret, one IDLE cycle, then int_req with active_id=3, int_addr=32'h130.
- mask=4'b1110, event on source 0 -> pending[0]=1, int_req stays 0. Set mask=4'hF -> int_req=1 after 1 edge, active_id=0, int_addr=32'h100.
- Two events on source 1 before ack -> overrun[1]=1. int_ack -> pending[1]=0, overrun[1]=0. A third event in the same cycle as int_ack -> pending[1]=1, overrun[1]=1.
- Assert reset while in SERVICE with pending=4'b1000 -> after 1 edge, all outputs at reset values and int_req=0. Stray int_ack or eret in IDLE -> no state change.
